// File: rtl/io_bus_responder.sv
// ============================================================================
// Module   : io_bus_responder
// Purpose  : Responder end of the board-level IO bus. Decodes a 4-word window
//            at BASE_ADDR and exposes an RX FIFO (device -> CPU) and a TX FIFO
//            (CPU -> device), plus status, occupancy counts and an interrupt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock     in     1  system clock, shared with the bus initiator
//   notReset  in     1  asynchronous active-low reset
//   address   in    16  bus address (window match on [15:2], offset on [1:0])
//   data      inout 16  bus data, driven only during a decoded read strobe
//   rd_n      in     1  active-low read strobe
//   wr_n      in     1  active-low write strobe
//   tx_data   out   16  TX FIFO head word
//   tx_valid  out    1  TX FIFO not empty
//   tx_ready  in     1  device takes tx_data on this edge
//   rx_data   in    16  word offered by the device
//   rx_valid  in     1  device offers rx_data
//   rx_ready  out    1  RX FIFO not full
//   irq_n     out    1  registered active-low interrupt
// Register map (offset = address[1:0])
//   0 DATA   : rd = RX head (0 when empty, pops at strobe end), wr = TX push
//   1 STATUS : {10'b0, rx_ovf, tx_ovf, tx_full, tx_empty, rx_full, rx_empty}
//              reading clears both overflow flags at strobe end
//   2 COUNT  : {rx_count[7:0], tx_count[7:0]}
//   3 CTRL   : wr bit0 flush RX, bit1 flush TX, bit2 irq_en; rd {13'b0,irq_en,2'b00}
// ============================================================================
`default_nettype none

module io_bus_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq_n
);

  localparam int unsigned    PW      = DEPTH_LOG2 + 1;
  localparam int unsigned    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0]  C_DEPTH = PW'(DEPTH);

  // Strobe tracking
  logic          rd_q, wr_q, rd_arm_q, wr_arm_q;
  logic          rd_hit_q, rd_hit_d;
  logic [1:0]    rd_off_q, rd_off_d;

  // FIFO storage and pointers
  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

  // Flags and control
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          flush_tx_q, flush_tx_d, flush_rx_q, flush_rx_d;
  logic [PW-1:0] stall_q, stall_d;
  logic          irq_n_q, irq_n_d;

  // Combinational decode
  logic          hit_w;
  logic          wr_start_w, rd_start_w, rd_end_w, wr_act_w;
  logic          tx_empty_w, tx_full_w, rx_empty_w, rx_full_w;
  logic          tx_push_w, tx_drop_w, tx_pop_w, rx_push_w, rx_pop_w;
  logic          ctrl_wr_w, ovf_clr_w, stall_w;
  logic [PW-1:0] tx_cnt_w, rx_cnt_w;
  logic [1:0]    off_w;
  logic [15:0]   rdata_w;
  logic          drive_w;

  assign hit_w = (address[15:2] == BASE_ADDR[15:2]);

  // A strobe already low when reset releases must not act: the arm flags
  // only set once the strobe has been seen high after reset.
  assign wr_start_w = ~wr_n & wr_q & wr_arm_q;
  // A read overlapping a write is ignored; the write takes effect.
  assign rd_start_w = ~rd_n & rd_q & rd_arm_q & wr_n;
  assign rd_end_w   = rd_n & ~rd_q & rd_hit_q;
  assign wr_act_w   = wr_start_w & hit_w;

  assign tx_empty_w = (tx_wr_q == tx_rd_q);
  assign tx_full_w  = (tx_wr_q[PW-1] != tx_rd_q[PW-1]) &&
                      (tx_wr_q[PW-2:0] == tx_rd_q[PW-2:0]);
  assign rx_empty_w = (rx_wr_q == rx_rd_q);
  assign rx_full_w  = (rx_wr_q[PW-1] != rx_rd_q[PW-1]) &&
                      (rx_wr_q[PW-2:0] == rx_rd_q[PW-2:0]);
  assign tx_cnt_w   = tx_wr_q - tx_rd_q;
  assign rx_cnt_w   = rx_wr_q - rx_rd_q;

  assign tx_push_w  = wr_act_w & (address[1:0] == 2'd0) & ~tx_full_w;
  assign tx_drop_w  = wr_act_w & (address[1:0] == 2'd0) &  tx_full_w;
  assign tx_pop_w   = ~tx_empty_w & tx_ready;
  assign rx_push_w  = rx_valid & ~rx_full_w;
  assign rx_pop_w   = rd_end_w & (rd_off_q == 2'd0) & ~rx_empty_w;
  assign ctrl_wr_w  = wr_act_w & (address[1:0] == 2'd3);
  assign ovf_clr_w  = rd_end_w & (rd_off_q == 2'd1);
  assign stall_w    = rx_valid & rx_full_w & ~flush_rx_q;

  assign tx_data  = tx_mem[tx_rd_q[DEPTH_LOG2-1:0]];
  assign tx_valid = ~tx_empty_w;
  assign rx_ready = ~rx_full_w;
  assign irq_n    = irq_n_q;

  // Before the start edge latches the offset, use the live address so data
  // is valid from the first cycle of the strobe.
  assign off_w = rd_q ? address[1:0] : rd_off_q;

  always_comb begin
    rdata_w = 16'h0000;
    case (off_w)
      2'd0:    rdata_w = rx_empty_w ? 16'h0000 : rx_mem[rx_rd_q[DEPTH_LOG2-1:0]];
      2'd1:    rdata_w = {10'b0, rx_ovf_q, tx_ovf_q, tx_full_w, tx_empty_w,
                          rx_full_w, rx_empty_w};
      2'd2:    rdata_w = {8'(rx_cnt_w), 8'(tx_cnt_w)};
      default: rdata_w = {13'b0, irq_en_q, 2'b00};
    endcase
  end

  assign drive_w = notReset & ~rd_n & wr_n & hit_w;
  assign data    = drive_w ? rdata_w : 16'hzzzz;

  // Next-state logic
  always_comb begin
    rd_hit_d   = rd_hit_q;
    rd_off_d   = rd_off_q;
    tx_wr_d    = tx_wr_q + PW'(tx_push_w);
    tx_rd_d    = tx_rd_q + PW'(tx_pop_w);
    rx_wr_d    = rx_wr_q + PW'(rx_push_w);
    rx_rd_d    = rx_rd_q + PW'(rx_pop_w);
    tx_ovf_d   = tx_ovf_q;
    rx_ovf_d   = rx_ovf_q;
    irq_en_d   = irq_en_q;
    flush_tx_d = ctrl_wr_w & data[1];
    flush_rx_d = ctrl_wr_w & data[0];
    stall_d    = '0;

    // Any edge where rd_n is freshly low re-evaluates the latched decode.
    if (~rd_n & rd_q) begin
      rd_hit_d = rd_start_w & hit_w;
      rd_off_d = address[1:0];
    end

    // Flush takes priority over any push or pop on the same edge.
    if (flush_tx_q) begin
      tx_wr_d = '0;
      tx_rd_d = '0;
    end
    if (flush_rx_q) begin
      rx_wr_d = '0;
      rx_rd_d = '0;
    end

    if (ovf_clr_w) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
    if (tx_drop_w) tx_ovf_d = 1'b1;

    // Count consecutive refused offers; overflow fires once per stall
    // episode, on the DEPTH-th full cycle, and the counter then saturates.
    if (stall_w) begin
      stall_d = (stall_q == C_DEPTH) ? stall_q : stall_q + 1'b1;
      if (stall_q == C_DEPTH - 1'b1) rx_ovf_d = 1'b1;
    end

    if (ctrl_wr_w) irq_en_d = data[2];

    irq_n_d = ~(irq_en_q & (~rx_empty_w | rx_ovf_q | tx_ovf_q));
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      rd_arm_q   <= 1'b0;
      wr_arm_q   <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_off_q   <= 2'd0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      flush_tx_q <= 1'b0;
      flush_rx_q <= 1'b0;
      stall_q    <= '0;
      irq_n_q    <= 1'b1;
    end else begin
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      rd_arm_q   <= rd_arm_q | rd_n;
      wr_arm_q   <= wr_arm_q | wr_n;
      rd_hit_q   <= rd_hit_d;
      rd_off_q   <= rd_off_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      irq_en_q   <= irq_en_d;
      flush_tx_q <= flush_tx_d;
      flush_rx_q <= flush_rx_d;
      stall_q    <= stall_d;
      irq_n_q    <= irq_n_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (tx_push_w) tx_mem[tx_wr_q[DEPTH_LOG2-1:0]] <= data;
    if (rx_push_w) rx_mem[rx_wr_q[DEPTH_LOG2-1:0]] <= rx_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_io_bus_responder.sv
`default_nettype none

module tb_io_bus_responder;

  logic        clock = 1'b0;
  logic        notReset;
  logic [15:0] address;
  tri1  [15:0] data_bus;
  logic        rd_n, wr_n;
  wire  [15:0] tx_data;
  wire         tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  wire         rx_ready;
  wire         irq_n;

  logic        tb_oe;
  logic [15:0] tb_wdata;

  // Undriven bus floats high through the tri1 net; 16'hFFFF means released.
  assign data_bus = tb_oe ? tb_wdata : 16'hzzzz;

  always #5 clock = ~clock;

  io_bus_responder dut (
    .clock    (clock),
    .notReset (notReset),
    .address  (address),
    .data     (data_bus),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq_n    (irq_n)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t rdq[$];
  exp_t txq[$];

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, want);
    end
  endtask

  // Monitor: every negedge where the DUT presents a bus read or a TX handshake
  // consumes one expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (notReset && !rd_n && wr_n && address[15:2] == 14'h3FC0) begin
      if (rdq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_read_unexpected actual=%h expected=none", data_bus);
      end else begin
        e = rdq.pop_front();
        chk(e.tag, data_bus, e.val);
      end
    end
    if (notReset && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_pop_unexpected actual=%h expected=none", tx_data);
      end else begin
        e = txq.pop_front();
        chk(e.tag, tx_data, e.val);
      end
    end
  end

  // All tasks start and end one time unit after a posedge.
  task automatic bus_read(input logic [15:0] addr, input int cycles,
                          input logic [15:0] want, input string tag);
    address = addr;
    rd_n    = 1'b0;
    for (int i = 0; i < cycles; i++) rdq.push_back('{val: want, tag: tag});
    repeat (cycles) @(posedge clock);
    #1 rd_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] val,
                           input int cycles);
    address  = addr;
    tb_wdata = val;
    tb_oe    = 1'b1;
    wr_n     = 1'b0;
    repeat (cycles) @(posedge clock);
    #1 wr_n = 1'b1;
    tb_oe   = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic dev_pop(input logic [15:0] want, input string tag);
    txq.push_back('{val: want, tag: tag});
    tx_ready = 1'b1;
    @(posedge clock);
    #1 tx_ready = 1'b0;
  endtask

  task automatic dev_push(input logic [15:0] val);
    rx_data  = val;
    rx_valid = 1'b1;
    @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    notReset = 1'b0;
    address  = 16'h0000;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 16'h0000;
    tb_oe    = 1'b0;
    tb_wdata = 16'h0000;
    repeat (3) @(posedge clock);
    #1 notReset = 1'b1;
    @(posedge clock);
    #1;

    // Reset state
    chk("reset_bus_released", data_bus, 16'hFFFF);
    chk("reset_irq_n", {15'b0, irq_n}, 16'h0001);
    chk("reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("reset_rx_ready", {15'b0, rx_ready}, 16'h0001);
    bus_read(16'hFF01, 1, 16'h0005, "status_after_reset");

    // Long write strobes act once each
    bus_write(16'hFF00, 16'h1234, 3);
    bus_write(16'hFF00, 16'hABCD, 3);
    bus_read(16'hFF02, 1, 16'h0002, "count_tx_two");
    chk("tx_valid_loaded", {15'b0, tx_valid}, 16'h0001);
    dev_pop(16'h1234, "tx_pop_first");
    dev_pop(16'hABCD, "tx_pop_second");
    chk("tx_valid_drained", {15'b0, tx_valid}, 16'h0000);

    // Fill RX, then stall one cycle short of overflow
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'hA000 + 16'(i);
      @(posedge clock);
      #1;
    end
    chk("rx_ready_full", {15'b0, rx_ready}, 16'h0000);
    rx_data = 16'hDEAD;
    repeat (7) @(posedge clock);
    #1 rx_valid = 1'b0;
    bus_read(16'hFF01, 1, 16'h0006, "status_stall_7_no_ovf");

    // Full stall of 8+ cycles sets overflow; reading STATUS clears it
    rx_valid = 1'b1;
    repeat (10) @(posedge clock);
    #1 rx_valid = 1'b0;
    bus_read(16'hFF01, 1, 16'h0026, "status_rx_ovf");
    bus_read(16'hFF01, 1, 16'h0006, "status_ovf_cleared");
    bus_read(16'hFF02, 1, 16'h0800, "count_rx_eight");

    // Two-cycle read pops once; drain the rest in order
    bus_read(16'hFF00, 2, 16'hA000, "rx_head_long_read");
    bus_read(16'hFF02, 1, 16'h0700, "count_after_single_pop");
    for (int i = 1; i < 8; i++)
      bus_read(16'hFF00, 1, 16'hA000 + 16'(i), "rx_drain");
    bus_read(16'hFF00, 1, 16'h0000, "rx_empty_read");
    bus_read(16'hFF02, 1, 16'h0000, "count_empty_after_read");

    // Interrupt path
    bus_write(16'hFF03, 16'h0004, 1);
    bus_read(16'hFF03, 1, 16'h0004, "ctrl_irq_en");
    dev_push(16'hBEEF);
    chk("irq_n_latency", {15'b0, irq_n}, 16'h0001);
    @(posedge clock);
    #1;
    chk("irq_n_asserted", {15'b0, irq_n}, 16'h0000);
    bus_read(16'hFF00, 1, 16'hBEEF, "rx_irq_word");
    @(posedge clock);
    #1;
    chk("irq_n_after_pop", {15'b0, irq_n}, 16'h0001);

    // TX overflow and flush
    for (int i = 0; i < 9; i++) bus_write(16'hFF00, 16'h5000 + 16'(i), 1);
    chk("irq_n_tx_ovf", {15'b0, irq_n}, 16'h0000);
    bus_read(16'hFF01, 1, 16'h0019, "status_tx_full_ovf");
    bus_read(16'hFF02, 1, 16'h0008, "count_tx_full");
    bus_write(16'hFF03, 16'h0006, 1);
    bus_read(16'hFF02, 1, 16'h0000, "count_after_tx_flush");
    bus_read(16'hFF01, 1, 16'h0005, "status_after_tx_flush");
    chk("tx_valid_after_flush", {15'b0, tx_valid}, 16'h0000);
    bus_write(16'hFF03, 16'h0000, 1);

    // Outside the window: bus stays released
    address = 16'hFE00;
    rd_n    = 1'b0;
    @(negedge clock);
    chk("outside_window_released", data_bus, 16'hFFFF);
    @(posedge clock);
    #1 rd_n = 1'b1;
    @(posedge clock);
    #1;

    // Reset in the middle of a read
    dev_push(16'hC001);
    dev_push(16'hC002);
    address = 16'hFF00;
    rd_n    = 1'b0;
    rdq.push_back('{val: 16'hC001, tag: "rx_head_before_reset"});
    @(negedge clock);
    #1 notReset = 1'b0;
    #1;
    chk("reset_mid_read_released", data_bus, 16'hFFFF);
    @(posedge clock);
    #1 rd_n = 1'b1;
    @(posedge clock);
    #1 notReset = 1'b1;
    @(posedge clock);
    #1;
    chk("irq_n_after_reset", {15'b0, irq_n}, 16'h0001);
    chk("rx_ready_after_reset", {15'b0, rx_ready}, 16'h0001);
    bus_read(16'hFF02, 1, 16'h0000, "count_after_reset");
    bus_read(16'hFF01, 1, 16'h0005, "status_after_mid_reset");

    @(posedge clock);
    #1;
    chk("read_queue_drained", 16'(rdq.size()), 16'h0000);
    chk("tx_queue_drained", 16'(txq.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
